pc_and_im: RTL and testbench

Instruction-fetch block for the single-issue MIPS-style datapath. It holds a 32-bit program counter (PC) that advances one word per clock, and a built-in read-only instruction memory addressed by that PC. It presents the fetched 32-bit instruction to the decode stage.

---
 rtl/pc_and_im.sv | 47 ++++
 tb/tb_pc_and_im.sv | 91 +++++++++
 2 files changed

// File: rtl/pc_and_im.sv
// Instruction fetch: a free-running word PC driving an asynchronous-read ROM.
// The PC wraps to zero after the last ROM word, so it never leaves the ROM.
module pc_and_im #(
  parameter int          DEPTH    = 64,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] InstructionOut,
  output logic [31:0] PCOut
);
  localparam int IDX_W = $clog2(DEPTH);

  // Declaration initialiser gives a defined fetch address before any reset edge.
  logic [31:0]      pc_q = RESET_PC;
  logic [31:0]      pc_d;
  logic [IDX_W-1:0] idx;
  logic [31:0]      rom_word;

  assign idx = pc_q[IDX_W+1:2];

  always_comb begin
    pc_d = pc_q + 32'd4;
    if (idx == IDX_W'(DEPTH - 1)) pc_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  always_comb begin
    rom_word = 32'h0000_0000;
    case (idx)
      IDX_W'(0): rom_word = 32'h2008_0005; // addi $t0,$zero,5
      IDX_W'(1): rom_word = 32'h2009_000A; // addi $t1,$zero,10
      IDX_W'(2): rom_word = 32'h0109_5020; // add  $t2,$t0,$t1
      IDX_W'(3): rom_word = 32'h012A_5822; // sub  $t3,$t1,$t2
      IDX_W'(4): rom_word = 32'hAC0A_0000; // sw   $t2,0($zero)
      IDX_W'(5): rom_word = 32'h8C0C_0000; // lw   $t4,0($zero)
      default:   rom_word = 32'h0000_0000;
    endcase
  end

  assign InstructionOut = rom_word;
  assign PCOut          = pc_q;
endmodule

// File: tb/tb_pc_and_im.sv
// Directed bench for pc_and_im: power-up, sequencing, wrap, reset override,
// held reset, and a non-zero RESET_PC instance.
module tb_pc_and_im;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rst2 = 1'b0;
  logic [31:0] instr, pc, instr2, pc2;
  int          n_chk = 0;
  int          n_fail = 0;

  logic [31:0] rom_exp [0:6] = '{32'h2008_0005, 32'h2009_000A, 32'h0109_5020,
                                 32'h012A_5822, 32'hAC0A_0000, 32'h8C0C_0000,
                                 32'h0000_0000};

  always #5 clk = ~clk;

  pc_and_im #(.DEPTH(64), .RESET_PC(32'h0)) u_dut (
    .clk(clk), .rst(rst), .InstructionOut(instr), .PCOut(pc));

  pc_and_im #(.DEPTH(64), .RESET_PC(32'h8)) u_dut8 (
    .clk(clk), .rst(rst2), .InstructionOut(instr2), .PCOut(pc2));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    chk("powerup_pc", pc, 32'h0);
    chk("powerup_instr", instr, 32'h2008_0005);
    chk("powerup_pc8", pc2, 32'h8);
    chk("powerup_instr8", instr2, 32'h0109_5020);

    rst = 1'b1;
    step();
    chk("reset_pc", pc, 32'h0);
    chk("reset_instr", instr, 32'h2008_0005);
    rst = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk($sformatf("seq_pc%0d", i), pc, 32'(4 * i));
      chk($sformatf("seq_instr%0d", i), instr, rom_exp[i]);
    end

    // PC is 24; 57 more edges reach the last word at 252.
    for (int i = 0; i < 57; i++) step();
    chk("end_pc", pc, 32'd252);
    chk("end_instr", instr, 32'h0);
    step();
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_instr", instr, 32'h2008_0005);

    for (int i = 0; i < 4; i++) step();
    chk("pre_rst_pc", pc, 32'd16);
    chk("pre_rst_instr", instr, 32'hAC0A_0000);
    rst = 1'b1;
    step();
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_instr", instr, 32'h2008_0005);

    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("hold_rst_pc%0d", i), pc, 32'h0);
    end
    rst = 1'b0;
    step();
    chk("rel_pc", pc, 32'h4);
    chk("rel_instr", instr, 32'h2009_000A);

    rst2 = 1'b1;
    step();
    chk("rst8_pc", pc2, 32'h8);
    chk("rst8_instr", instr2, 32'h0109_5020);
    rst2 = 1'b0;
    step();
    chk("rst8_next_pc", pc2, 32'd12);
    chk("rst8_next_instr", instr2, 32'h012A_5822);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
